// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - datapath load/store request and response bus
interface dmem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_rd_en;
    logic              req_wr_en;
    logic              req_byte;
    logic              req_half;
    logic              req_word;
    logic              req_unsigned;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DWIDTH-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_rd_en, req_wr_en, req_byte, req_half, req_word, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_rd_en, req_wr_en, req_byte, req_half, req_word, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder in front of a fixed-latency word SRAM
module dmem_responder #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   req_if,
    output logic [AWIDTH-3:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_MERGE_WR, S_WR, S_RESP
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              byte_q, byte_d;
    logic              half_q, half_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;

    logic              accept;
    logic              size_ok;
    logic              req_bad;
    logic [4:0]        lane_sh;
    logic [DWIDTH-1:0] lane_data;
    logic [DWIDTH-1:0] lane_mask;
    logic [DWIDTH-1:0] load_data;
    logic [DWIDTH-1:0] merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        size_ok = 1'b0;
        case ({req_if.req_byte, req_if.req_half, req_if.req_word})
            3'b100, 3'b010, 3'b001: size_ok = 1'b1;
            default:                size_ok = 1'b0;
        endcase
    end

    assign accept  = (state_q == S_IDLE) && (req_if.req_rd_en || req_if.req_wr_en);
    assign req_bad = (req_if.req_rd_en && req_if.req_wr_en) || !size_ok ||
                     (req_if.req_half && req_if.req_addr[0]) ||
                     (req_if.req_word && (req_if.req_addr[1:0] != 2'b00));

    // Word accesses are aligned, so the lane shift collapses to zero for them.
    assign lane_sh   = half_q ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    assign lane_data = rdata_q >> lane_sh;
    assign lane_mask = (byte_q ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    assign merged    = (rdata_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

    always_comb begin
        if (byte_q)
            load_data = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
        else if (half_q)
            load_data = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
        else
            load_data = rdata_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        half_d  = half_q;
        uns_d   = uns_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_if.req_addr;
                    wdata_d = req_if.req_wdata;
                    wr_d    = req_if.req_wr_en;
                    byte_d  = req_if.req_byte;
                    half_d  = req_if.req_half;
                    uns_d   = req_if.req_unsigned;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = S_RESP;
                    else if (req_if.req_wr_en && req_if.req_word)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                cnt_d   = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = wr_q ? S_MERGE_WR : S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_MERGE_WR: state_d = S_RESP;
            S_WR:       state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign mem_addr = addr_q[AWIDTH-1:2];

    always_comb begin
        req_if.req_ready  = (state_q == S_IDLE);
        req_if.resp_valid = (state_q == S_RESP);
        req_if.resp_err   = (state_q == S_RESP) && err_q;
        req_if.resp_rdata = ((state_q == S_RESP) && !err_q && !wr_q) ? load_data : '0;
        mem_rd            = (state_q == S_RD);
        mem_wr            = (state_q == S_WR) || (state_q == S_MERGE_WR);
        mem_wdata         = '0;
        if (state_q == S_WR)
            mem_wdata = wdata_q;
        else if (state_q == S_MERGE_WR)
            mem_wdata = merged;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized check of dmem_responder at latencies 1 and 3
module tb_dmem_responder;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_a ();
    dmem_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_b ();

    logic [AW-3:0] mem_addr_a, mem_addr_b;
    logic          mem_rd_a, mem_rd_b, mem_wr_a, mem_wr_b;
    logic [DW-1:0] mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;

    dmem_responder #(.DWIDTH(DW), .AWIDTH(AW), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .req_if(bus_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    dmem_responder #(.DWIDTH(DW), .AWIDTH(AW), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .req_if(bus_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    logic [31:0] sram_a [64];
    logic [31:0] sram_b [64];
    logic [31:0] ref_mem [64];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en) sram_a[pre_idx] <= pre_val;
        else if (mem_wr_a) sram_a[mem_addr_a[5:0]] <= mem_wdata_a;
        pipe_a <= mem_rd_a ? sram_a[mem_addr_a[5:0]] : 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (pre_en) sram_b[pre_idx] <= pre_val;
        else if (mem_wr_b) sram_b[mem_addr_b[5:0]] <= mem_wdata_b;
        pipe_b[0] <= mem_rd_b ? sram_b[mem_addr_b[5:0]] : 32'hBAD0_BAD0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    assign mem_rdata_a = pipe_a;
    assign mem_rdata_b = pipe_b[2];

    int n_tests = 0;
    int n_fail  = 0;

    int          n_resp [2], seen [2], n_rd [2], n_wr [2], bad_addr [2], both [2], rdy_bad [2];
    logic [31:0] g_err [2], g_rdata [2], g_wd [2];
    logic [29:0] exp_maddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic rd, wr, b, h, w, uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus_a.req_rd_en = rd;  bus_b.req_rd_en = rd;
        bus_a.req_wr_en = wr;  bus_b.req_wr_en = wr;
        bus_a.req_byte  = b;   bus_b.req_byte  = b;
        bus_a.req_half  = h;   bus_b.req_half  = h;
        bus_a.req_word  = w;   bus_b.req_word  = w;
        bus_a.req_unsigned = uns; bus_b.req_unsigned = uns;
        bus_a.req_addr  = addr;  bus_b.req_addr  = addr;
        bus_a.req_wdata = wdata; bus_b.req_wdata = wdata;
    endtask

    task automatic drive_idle();
        drive_req(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom);
    endtask

    task automatic preset(input int idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic observe(input int d, input int cyc, input int lat,
                           input logic vld, input logic err, input logic [31:0] rdata,
                           input logic rdy, input logic rd, input logic wr,
                           input logic [29:0] ma, input logic [31:0] wd);
        if (vld) begin
            n_resp[d]++;
            if (n_resp[d] == 1) begin
                seen[d]    = cyc;
                g_err[d]   = {31'b0, err};
                g_rdata[d] = rdata;
            end
        end
        if (rd) n_rd[d]++;
        if (wr) begin
            n_wr[d]++;
            g_wd[d] = wd;
        end
        if ((rd || wr) && ma !== exp_maddr) bad_addr[d]++;
        if (rd && wr) both[d]++;
        if (rdy !== (cyc > lat)) rdy_bad[d]++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready_a"}, {31'b0, bus_a.req_ready}, 32'd1);
        check({tag, "/ready_b"}, {31'b0, bus_b.req_ready}, 32'd1);
        check({tag, "/valid"}, {30'b0, bus_a.resp_valid, bus_b.resp_valid}, 32'd0);
        check({tag, "/err"}, {30'b0, bus_a.resp_err, bus_b.resp_err}, 32'd0);
        check({tag, "/rdata"}, bus_a.resp_rdata | bus_b.resp_rdata, 32'd0);
        check({tag, "/strobes"}, {28'b0, mem_rd_a, mem_wr_a, mem_rd_b, mem_wr_b}, 32'd0);
        check({tag, "/mem_addr"}, {2'b0, mem_addr_a | mem_addr_b}, 32'd0);
        check({tag, "/mem_wdata"}, mem_wdata_a | mem_wdata_b, 32'd0);
    endtask

    task automatic run_req(input string tag, input logic rd, wr, b, h, w, uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic        e;
        logic [31:0] er, old, nw, val, mask;
        int          off, idx, nsz, erd, ewr;
        int          lat [2];
        int          lval;

        nsz = int'(b) + int'(h) + int'(w);
        e   = (rd && wr) || nsz != 1 || (h && addr % 2 != 0) || (w && addr % 4 != 0);
        idx = int'((addr / 4) % 64);
        off = int'(addr % 4);
        old = ref_mem[idx];
        er  = 32'd0;
        erd = 0;
        ewr = 0;
        nw  = old;
        if (!e && rd) begin
            erd = 1;
            if (w) er = old;
            else if (h) begin
                val = (old >> (8 * off)) & 32'hFFFF;
                if (!uns && val >= 32'h8000) val = val + 32'hFFFF_0000;
                er = val;
            end else begin
                val = (old >> (8 * off)) & 32'hFF;
                if (!uns && val >= 32'h80) val = val + 32'hFFFF_FF00;
                er = val;
            end
        end
        if (!e && wr) begin
            ewr = 1;
            if (w) nw = wdata;
            else begin
                erd  = 1;
                mask = h ? 32'hFFFF : 32'hFF;
                nw   = (old & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            end
            ref_mem[idx] = nw;
        end
        for (int k = 0; k < 2; k++) begin
            lval = (k == 0) ? 1 : 3;
            if (e) lat[k] = 1;
            else if (rd) lat[k] = 2 + lval;
            else if (w) lat[k] = 2;
            else lat[k] = 3 + lval;
            n_resp[k] = 0; seen[k] = 0; n_rd[k] = 0; n_wr[k] = 0;
            bad_addr[k] = 0; both[k] = 0; rdy_bad[k] = 0;
            g_err[k] = '0; g_rdata[k] = '0; g_wd[k] = '0;
        end
        exp_maddr = addr[31:2];

        @(negedge clk);
        check({tag, "/ready_in"}, {30'b0, bus_a.req_ready, bus_b.req_ready}, 32'd3);
        drive_req(rd, wr, b, h, w, uns, addr, wdata);
        @(posedge clk);
        #1 drive_idle();
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            observe(0, cyc, lat[0], bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata,
                    bus_a.req_ready, mem_rd_a, mem_wr_a, mem_addr_a, mem_wdata_a);
            observe(1, cyc, lat[1], bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata,
                    bus_b.req_ready, mem_rd_b, mem_wr_b, mem_addr_b, mem_wdata_b);
        end
        for (int k = 0; k < 2; k++) begin
            string p;
            p = $sformatf("%s/L%0d", tag, (k == 0) ? 1 : 3);
            check({p, "/resp_count"}, 32'(n_resp[k]), 32'd1);
            check({p, "/resp_cycle"}, 32'(seen[k]), 32'(lat[k]));
            check({p, "/err"}, g_err[k], {31'b0, e});
            check({p, "/rdata"}, g_rdata[k], er);
            check({p, "/mem_rd_count"}, 32'(n_rd[k]), 32'(erd));
            check({p, "/mem_wr_count"}, 32'(n_wr[k]), 32'(ewr));
            if (ewr != 0) check({p, "/mem_wdata"}, g_wd[k], nw);
            check({p, "/mem_addr"}, 32'(bad_addr[k]), 32'd0);
            check({p, "/rd_wr_overlap"}, 32'(both[k]), 32'd0);
            check({p, "/ready"}, 32'(rdy_bad[k]), 32'd0);
        end
    endtask

    task automatic reset_during_wait();
        int hits;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0042, $urandom);
        @(posedge clk);
        #1 drive_idle();
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst_wait");
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_rd_a || mem_wr_a || mem_rd_b || mem_wr_b ||
                bus_a.resp_valid || bus_b.resp_valid) hits++;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_rd_a || mem_wr_a || mem_rd_b || mem_wr_b ||
                bus_a.resp_valid || bus_b.resp_valid || !bus_a.req_ready || !bus_b.req_ready)
                hits++;
        end
        check("rst_wait/quiet", 32'(hits), 32'd0);
    endtask

    initial begin
        logic        rd, wr, b, h, w;
        logic [31:0] addr;
        int          sz;

        drive_idle();
        for (int i = 0; i < 64; i++) preset(i, $urandom);
        preset(32'h10 >> 2, 32'hDEAD_BEEF);
        preset(32'h20 >> 2, 32'h80FF_7F01);
        preset(32'h40 >> 2, 32'h1122_3344);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        run_req("lw_10",  1, 0, 0, 0, 1, 0, 32'h10, 32'h0);
        run_req("lb_23",  1, 0, 1, 0, 0, 0, 32'h23, 32'h0);
        run_req("lbu_23", 1, 0, 1, 0, 0, 1, 32'h23, 32'h0);
        run_req("lb_20",  1, 0, 1, 0, 0, 0, 32'h20, 32'h0);
        run_req("lh_22",  1, 0, 0, 1, 0, 0, 32'h22, 32'h0);
        run_req("sb_41",  0, 1, 1, 0, 0, 0, 32'h41, 32'hAB);
        run_req("lw_40",  1, 0, 0, 0, 1, 0, 32'h40, 32'h0);
        run_req("err_h3", 1, 0, 0, 1, 0, 0, 32'h03, 32'h0);
        run_req("err_w6", 1, 0, 0, 0, 1, 0, 32'h06, 32'h0);
        run_req("err_rw", 1, 1, 0, 0, 1, 0, 32'h00, 32'h0);
        run_req("err_bw", 1, 0, 1, 0, 1, 0, 32'h00, 32'h0);

        reset_during_wait();
        run_req("lw_after_rst", 1, 0, 0, 0, 1, 0, 32'h40, 32'h0);

        for (int t = 0; t < 70; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                {rd, wr, b, h, w} = 5'($urandom);
                if (!rd && !wr) rd = 1'b1;
            end else begin
                rd = 1'($urandom);
                wr = !rd;
                sz = $urandom_range(0, 2);
                {b, h, w} = (sz == 0) ? 3'b100 : (sz == 1) ? 3'b010 : 3'b001;
                if ($urandom_range(0, 7) != 0)
                    addr = w ? (addr & ~32'd3) : h ? (addr & ~32'd1) : addr;
            end
            run_req($sformatf("rnd%0d", t), rd, wr, b, h, w, 1'($urandom), addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
